// File: rtl/timer_pkg.sv
// Shared definitions for the down-counting interval timer.
// The state encoding is fixed so that debug probes and decoders elsewhere agree on it.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/down_count_core.sv
// Count register with clear, load, decrement and hold, plus an is_one flag.
// The flag tells the controller that the next step is the terminal one.
module down_count_core #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load,
   input  logic             dec,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             is_one
);

   // clear wins over load, and load wins over decrement; with none of them the count holds
   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (load)
         count <= load_value;
      else if (dec)
         count <= count - 1'b1;
   end

   assign is_one = (count == WIDTH'(1));

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counting timer with a load handshake, pause/stop and optional auto-reload.
// Raises a one-cycle tc pulse on terminal count and a one-cycle err pulse on a zero load.
module down_counter_timer
   import timer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_value,
   output logic             load_ready,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] out,
   output logic             busy,
   output logic             tc,
   output logic             err
);

   state_t           state;
   logic [WIDTH-1:0] reload_reg;
   logic             is_one;
   logic             accept, load_nz, load_zero;
   logic             start_armed, start_done, run_step, terminal;
   logic             core_clear, core_load, core_dec;
   logic [WIDTH-1:0] core_value;

   assign load_ready = (state != RUN);

   // A zero load still consumes the cycle, so a start arriving with it is dropped too
   always_comb begin
      accept      = load_valid && load_ready;
      load_nz     = accept && (load_value != '0);
      load_zero   = accept && (load_value == '0);
      start_armed = !accept && start && (state == ARMED);
      start_done  = !accept && start && (state == DONE);
      run_step    = (state == RUN) && !pause;
      terminal    = run_step && is_one;
      core_clear  = stop || (terminal && !auto_reload);
      core_load   = !stop && (load_nz || start_done || (terminal && auto_reload));
      core_dec    = !stop && run_step && !is_one;
      core_value  = load_nz ? load_value : reload_reg;
   end

   down_count_core #(.WIDTH(WIDTH)) u_core (
      .clk        (clk),
      .rst        (rst),
      .clear      (core_clear),
      .load       (core_load),
      .dec        (core_dec),
      .load_value (core_value),
      .count      (out),
      .is_one     (is_one)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         reload_reg <= '0;
         busy       <= 1'b0;
         tc         <= 1'b0;
         err        <= 1'b0;
      end else begin
         tc  <= 1'b0;
         err <= 1'b0;
         if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else if (load_nz) begin
            reload_reg <= load_value;
            state      <= ARMED;
            busy       <= 1'b0;
         end else if (load_zero) begin
            err <= 1'b1;
         end else if (start_armed || start_done) begin
            state <= RUN;
            busy  <= 1'b1;
         end else if (terminal) begin
            tc <= 1'b1;
            if (!auto_reload) begin
               state <= DONE;
               busy  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_down_counter_timer.sv
// Randomized bench for down_counter_timer, checked every cycle against a behavioural model.
// Directed sequences with literal expectations come first to pin the model itself.
module tb_down_counter_timer;

   localparam int W = 8;
   localparam int PH_IDLE = 0, PH_ARMED = 1, PH_RUN = 2, PH_DONE = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         load_valid = 1'b0;
   logic [W-1:0] load_value = '0;
   logic         start = 1'b0, stop = 1'b0, pause = 1'b0, auto_reload = 1'b0;
   logic         load_ready, busy, tc, err;
   logic [W-1:0] out;

   int total = 0;
   int bad = 0;
   bit checkEn = 1'b0;

   int mPhase, mCount, mReload;
   bit mBusy, mTc, mErr;

   down_counter_timer #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .load_valid  (load_valid),
      .load_value  (load_value),
      .load_ready  (load_ready),
      .start       (start),
      .stop        (stop),
      .pause       (pause),
      .auto_reload (auto_reload),
      .out         (out),
      .busy        (busy),
      .tc          (tc),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one step of the timer's rules per rising edge
   always @(posedge clk) begin
      if (rst) begin
         mPhase = PH_IDLE; mCount = 0; mReload = 0;
         mBusy = 0; mTc = 0; mErr = 0;
      end else begin
         mTc = 0; mErr = 0;
         if (stop) begin
            mPhase = PH_IDLE; mCount = 0;
         end else if (load_valid && mPhase != PH_RUN) begin
            if (load_value == 0) mErr = 1;
            else begin
               mReload = int'(load_value); mCount = mReload; mPhase = PH_ARMED;
            end
         end else if (start && mPhase == PH_ARMED) begin
            mPhase = PH_RUN;
         end else if (start && mPhase == PH_DONE) begin
            mCount = mReload; mPhase = PH_RUN;
         end else if (mPhase == PH_RUN && !pause) begin
            if (mCount == 1) begin
               mTc = 1;
               if (auto_reload) mCount = mReload;
               else begin mCount = 0; mPhase = PH_DONE; end
            end else mCount = mCount - 1;
         end
         mBusy = (mPhase == PH_RUN);
      end
   end

   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("model_out", int'(out), mCount);
         checkOutput("model_busy", int'(busy), int'(mBusy));
         checkOutput("model_tc", int'(tc), int'(mTc));
         checkOutput("model_err", int'(err), int'(mErr));
         checkOutput("model_ready", int'(load_ready), int'(mPhase != PH_RUN));
      end
   end

   task automatic applyStimulus(input logic lv, input logic [W-1:0] val, input logic st,
                                input logic sp, input logic ps, input logic ar, input logic r);
      load_valid = lv; load_value = val; start = st; stop = sp;
      pause = ps; auto_reload = ar; rst = r;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input logic ar);
      applyStimulus(0, '0, 0, 0, 0, ar, 0);
   endtask

   task automatic checkResetState();
      checkOutput("rst_out", int'(out), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_tc", int'(tc), 0);
      checkOutput("rst_err", int'(err), 0);
      checkOutput("rst_ready", int'(load_ready), 1);
   endtask

   initial begin
      int seqA[5] = '{4, 3, 2, 1, 0};
      int seqB[9] = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
      logic         lv, st, sp, ps, ar, r;
      logic [W-1:0] val;

      applyStimulus(0, '0, 0, 0, 0, 0, 1);
      applyStimulus(0, '0, 0, 0, 0, 0, 1);
      checkEn = 1'b1;
      checkResetState();

      // one-shot with a pause window, then rerun from the reload value
      applyStimulus(1, 8'd5, 0, 0, 0, 0, 0);
      checkOutput("load5_out", int'(out), 5);
      checkOutput("load5_ready", int'(load_ready), 1);
      applyStimulus(0, '0, 1, 0, 0, 0, 0);
      checkOutput("start_out", int'(out), 5);
      checkOutput("start_busy", int'(busy), 1);
      checkOutput("start_ready", int'(load_ready), 0);
      idle(0);
      checkOutput("dec_out", int'(out), 4);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, '0, 0, 0, 1, 0, 0);
         checkOutput("pause_out", int'(out), 4);
         checkOutput("pause_tc", int'(tc), 0);
      end
      for (int i = 1; i < 5; i++) begin
         idle(0);
         checkOutput("oneshot_out", int'(out), seqA[i]);
         checkOutput("oneshot_tc", int'(tc), (seqA[i] == 0) ? 1 : 0);
      end
      checkOutput("done_busy", int'(busy), 0);
      idle(0);
      checkOutput("tc_pulse_end", int'(tc), 0);
      applyStimulus(0, '0, 1, 0, 0, 0, 0);
      checkOutput("rerun_out", int'(out), 5);
      checkOutput("rerun_busy", int'(busy), 1);

      // load held during the run is not captured until DONE
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 8'd7, 0, 0, 0, 0, 0);
         checkOutput("hs_out", int'(out), seqA[i]);
      end
      applyStimulus(1, 8'd7, 0, 0, 0, 0, 0);
      checkOutput("hs_capture", int'(out), 7);

      applyStimulus(1, 8'd0, 0, 0, 0, 0, 0);
      checkOutput("zero_err", int'(err), 1);
      checkOutput("zero_out", int'(out), 7);
      idle(0);
      checkOutput("zero_err_end", int'(err), 0);

      // stop mid-run, then start from IDLE is ignored
      applyStimulus(0, '0, 1, 0, 0, 0, 0);
      idle(0);
      checkOutput("pre_stop_out", int'(out), 6);
      applyStimulus(0, '0, 0, 1, 0, 0, 0);
      checkOutput("stop_out", int'(out), 0);
      checkOutput("stop_busy", int'(busy), 0);
      applyStimulus(0, '0, 1, 0, 0, 0, 0);
      checkOutput("idle_start_busy", int'(busy), 0);

      // load plus start in DONE: load wins
      applyStimulus(1, 8'd2, 0, 0, 0, 0, 0);
      applyStimulus(0, '0, 1, 0, 0, 0, 0);
      idle(0);
      idle(0);
      checkOutput("collide_pre_tc", int'(tc), 1);
      applyStimulus(1, 8'd9, 1, 0, 0, 0, 0);
      checkOutput("collide_out", int'(out), 9);
      checkOutput("collide_busy", int'(busy), 0);
      idle(0);
      checkOutput("collide_hold", int'(out), 9);

      // periodic ticks with L=3, then L=1
      applyStimulus(1, 8'd3, 0, 0, 0, 1, 0);
      applyStimulus(0, '0, 1, 0, 0, 1, 0);
      checkOutput("ar_start_out", int'(out), 3);
      for (int i = 0; i < 9; i++) begin
         idle(1);
         checkOutput("ar_out", int'(out), seqB[i]);
         checkOutput("ar_tc", int'(tc), (i % 3 == 2) ? 1 : 0);
         checkOutput("ar_busy", int'(busy), 1);
      end
      applyStimulus(0, '0, 0, 1, 0, 1, 0);
      applyStimulus(1, 8'd1, 0, 0, 0, 1, 0);
      applyStimulus(0, '0, 1, 0, 0, 1, 0);
      checkOutput("l1_tc0", int'(tc), 0);
      for (int i = 0; i < 4; i++) begin
         idle(1);
         checkOutput("l1_out", int'(out), 1);
         checkOutput("l1_tc", int'(tc), 1);
      end

      // reset in the middle of a long run
      applyStimulus(0, '0, 0, 1, 0, 0, 0);
      applyStimulus(1, 8'd255, 0, 0, 0, 0, 0);
      applyStimulus(0, '0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 55; i++) idle(0);
      checkOutput("midrun_out", int'(out), 200);
      applyStimulus(0, '0, 0, 0, 0, 0, 1);
      applyStimulus(0, '0, 0, 0, 0, 0, 1);
      checkResetState();

      for (int n = 0; n < 4000; n++) begin
         r  = ($urandom_range(0, 199) == 0);
         lv = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 7) == 0) val = '0;
         else if ($urandom_range(0, 9) == 0) val = W'($urandom_range(1, 255));
         else val = W'($urandom_range(1, 8));
         st = ($urandom_range(0, 4) == 0);
         sp = ($urandom_range(0, 49) == 0);
         ps = ($urandom_range(0, 5) == 0);
         ar = 1'($urandom_range(0, 1));
         applyStimulus(lv, val, st, sp, ps, ar, r);
      end

      checkEn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
